// File: rtl/alu_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
// state_t : FSM encoding (IDLE / RUN / DONE)
// cmp_t   : result code produced by one compare step
package alu_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmp_t;

endpackage

// File: rtl/serial_mag_comparator_cmp2_slice.sv
// cmp2_slice: combinational 2-bit magnitude compare.
// Ports:
//   x, y : 2-bit operands
//   eq   : x == y
//   gt   : x >  y
//   lt   : x <  y
module cmp2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       eq,
    output logic       gt,
    output logic       lt
);

    assign eq = (x == y);
    assign gt = (x >  y);
    assign lt = (x <  y);

endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: multi-cycle magnitude compare, two bits per cycle,
// MSB pair first, stopping at the first differing pair.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a compare (taken only when not busy)
//   a, b       : operands, sampled on the accepting edge
//   busy       : compare in progress
//   done       : one-cycle pulse when eq/gt/lt become valid
//   eq, gt, lt : one-hot result, held until the next accepted start
import alu_cmp_pkg::*;

module serial_mag_comparator #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int PAIRS = WIDTH / 2;
    localparam int CW    = $clog2(PAIRS) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(PAIRS);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] MSB_MASK = {SIGNED, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             pair_eq, pair_gt, pair_lt;
    logic             accept, finish;
    cmp_t             res;

    cmp2_slice u_slice (
        .x  (sa[WIDTH-1 -: 2]),
        .y  (sb[WIDTH-1 -: 2]),
        .eq (pair_eq),
        .gt (pair_gt),
        .lt (pair_lt)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        res     = CMP_EQ;
        if (pair_gt)      res = CMP_GT;
        else if (pair_lt) res = CMP_LT;

        case (state_q)
            // DONE accepts exactly like IDLE so back-to-back compares need no bubble.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!pair_eq || cnt == CNT_LAST) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= finish;
            if (accept) begin
                sa   <= a ^ MSB_MASK;
                sb   <= b ^ MSB_MASK;
                cnt  <= CNT_INIT;
                busy <= 1'b1;
                eq   <= 1'b0;
                gt   <= 1'b0;
                lt   <= 1'b0;
            end else if (finish) begin
                busy <= 1'b0;
                eq   <= (res == CMP_EQ);
                gt   <= (res == CMP_GT);
                lt   <= (res == CMP_LT);
            end else if (state_q == ST_RUN) begin
                // Pair was equal and more remain: bring the next pair to the top.
                sa  <= sa << 2;
                sb  <= sb << 2;
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator: an unsigned and a signed
// instance share clock/reset; stimulus pushes expected {eq,gt,lt} and
// latency, per-instance monitors pop and compare on every done pulse.
module tb_serial_mag_comparator;

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    typedef struct {
        logic [2:0] flags;
        int         lat;
        int         acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_u, start_s;
    logic [31:0] a_u, b_u, a_s, b_s;
    logic        busy_u, done_u, eq_u, gt_u, lt_u;
    logic        busy_s, done_s, eq_s, gt_s, lt_s;

    exp_t q_u[$];
    exp_t q_s[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_mag_comparator #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start_u), .a(a_u), .b(b_u),
        .busy(busy_u), .done(done_u), .eq(eq_u), .gt(gt_u), .lt(lt_u)
    );

    serial_mag_comparator #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_s), .b(b_s),
        .busy(busy_s), .done(done_s), .eq(eq_s), .gt(gt_s), .lt(lt_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic mon(input bit sel, input logic [2:0] fl);
        exp_t e;
        if ((sel ? q_s.size() : q_u.size()) == 0) begin
            total_cnt++;
            $display("FAIL %s_unexpected_done: got flags %b expected no done", sel ? "s" : "u", fl);
        end else begin
            e = sel ? q_s.pop_front() : q_u.pop_front();
            chk(sel ? "s_flags" : "u_flags", {29'd0, fl}, {29'd0, e.flags});
            chk(sel ? "s_latency" : "u_latency", cyc - e.acc, e.lat);
        end
    endtask

    always @(negedge clk) if (rst_n && done_u) mon(1'b0, {eq_u, gt_u, lt_u});
    always @(negedge clk) if (rst_n && done_s) mon(1'b1, {eq_s, gt_s, lt_s});

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic [2:0] fl, input int lat, input bit push);
        exp_t e;
        e.flags = fl;
        e.lat   = lat;
        e.acc   = cyc + 1;
        if (sel) begin
            a_s = av; b_s = bv; start_s = 1'b1;
            if (push) q_s.push_back(e);
        end else begin
            a_u = av; b_u = bv; start_u = 1'b1;
            if (push) q_u.push_back(e);
        end
        @(negedge clk);
        start_u = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        bit ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (sel) ok = (q_s.size() == 0) && !busy_s && !done_s;
            else     ok = (q_u.size() == 0) && !busy_u && !done_u;
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL %s_timeout: got no result expected done within 40 cycles", sel ? "s" : "u");
            if (sel) q_s.delete(); else q_u.delete();
        end
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0;
        start_u = 1'b1; start_s = 1'b1;
        a_u = 32'h0; b_u = 32'h0; a_s = 32'h0; b_s = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_u", {27'd0, busy_u, done_u, eq_u, gt_u, lt_u}, 32'd0);
        chk("reset_s", {27'd0, busy_s, done_s, eq_s, gt_s, lt_s}, 32'd0);
        start_u = 1'b0; start_s = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 32'h0, 32'h0, EQ, 16, 1);               wait_idle(0);

        issue(0, 32'h8000_0000, 32'h0, GT, 1, 1);
        chk("early_busy_hi", {31'd0, busy_u}, 32'd1);
        @(negedge clk);
        chk("early_busy_lo", {31'd0, busy_u}, 32'd0);
        wait_idle(0);

        issue(0, 32'h4000_0000, 32'h8000_0000, LT, 1, 1);  wait_idle(0);
        issue(0, 32'h0C00_0000, 32'h0800_0000, GT, 3, 1);  wait_idle(0);
        issue(0, 32'h0000_0003, 32'h0000_0002, GT, 16, 1); wait_idle(0);
        issue(0, 32'hFFFF_FFFF, 32'h0000_0001, GT, 1, 1);  wait_idle(0);

        issue(1, 32'hFFFF_FFFF, 32'h0000_0001, LT, 1, 1);  wait_idle(1);
        issue(1, 32'h8000_0000, 32'h7FFF_FFFF, LT, 1, 1);  wait_idle(1);
        issue(1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, LT, 16, 1); wait_idle(1);
        issue(1, 32'h0000_0005, 32'h0000_0005, EQ, 16, 1); wait_idle(1);

        // start pulsed mid-compare with other operands must be ignored
        issue(0, 32'h1234_5678, 32'h1234_5679, LT, 16, 1);
        repeat (2) @(negedge clk);
        a_u = 32'hFFFF_FFFF; b_u = 32'h0; start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        wait_idle(0);

        // back-to-back: new start taken in the DONE cycle
        issue(0, 32'h0001_0000, 32'h0000_FFFF, GT, 8, 1);
        repeat (8) @(negedge clk);
        chk("b2b_done", {31'd0, done_u}, 32'd1);
        issue(0, 32'h5, 32'h5, EQ, 16, 1);
        chk("b2b_flags_clr", {29'd0, eq_u, gt_u, lt_u}, 32'd0);
        chk("b2b_busy", {31'd0, busy_u}, 32'd1);
        wait_idle(0);

        // reset in the middle of a compare
        issue(0, 32'h0, 32'h0, EQ, 16, 0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midreset_async", {27'd0, busy_u, done_u, eq_u, gt_u, lt_u}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_u) ndone++;
        end
        chk("midreset_no_done", ndone, 0);
        issue(0, 32'h2, 32'h1, GT, 16, 1);                 wait_idle(0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
